// File: rtl/poly_word_adder.sv
// poly_word_adder
// ---------------------------------------------------------------------------
// Adds two packed small polynomials lane-wise modulo Q and writes the result
// back as packed words. Each 96-bit word holds 8 lanes of 12-bit coefficients,
// with lane j in bits [12j+11:12j]. Lanes are combined position-for-position,
// so any coefficient interleaving in the source words is preserved.
//
// Optional feature (macro POLY_WORD_SUB_EN): adds input `sub`, latched at
// start. When sub = 1 each lane computes (a - b) mod Q instead of (a + b) mod Q.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start                         one-cycle request, sampled only in IDLE
//   a_offset, b_offset, dst_offset base addresses, latched on accepted start
//   ren, raddr_a, raddr_b         shared read enable and operand read addresses
//   rdata_a, rdata_b              operand words, valid one cycle after ren
//   enw, waddr, dout              result write strobe, address and word
//   busy                          high from accepted start until done rises
//   done                          sticky completion flag, cleared by next start
//
// Pipeline (start sampled at edge 0): read k issued after edge k+1, data
// valid after edge k+2, write k issued after edge k+3.
// ---------------------------------------------------------------------------
module poly_word_adder #(
    parameter int WORDS = 32,
    parameter int AW    = 10,
    parameter int Q     = 3329
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a_offset,
    input  logic [AW-1:0] b_offset,
    input  logic [AW-1:0] dst_offset,
`ifdef POLY_WORD_SUB_EN
    input  logic          sub,
`endif
    output logic          ren,
    output logic [AW-1:0] raddr_a,
    output logic [AW-1:0] raddr_b,
    input  logic [95:0]   rdata_a,
    input  logic [95:0]   rdata_b,
    output logic          enw,
    output logic [AW-1:0] waddr,
    output logic [95:0]   dout,
    output logic          busy,
    output logic          done
);

    localparam logic [12:0]   Q13  = 13'(Q);
    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] rc_r;
    logic [AW-1:0] wc_r;
    logic [AW-1:0] a_off_r;
    logic [AW-1:0] b_off_r;
    logic [AW-1:0] dst_off_r;
    logic          ren_r;
    logic          vld_r;
    logic          enw_r;
    logic [AW-1:0] raddr_a_r;
    logic [AW-1:0] raddr_b_r;
    logic [AW-1:0] waddr_r;
    logic [95:0]   dout_r;
    logic          busy_r;
    logic          done_r;
    logic [95:0]   dout_s;
`ifdef POLY_WORD_SUB_EN
    logic          sub_r;
`endif

    // One-step conditional subtraction; the 13-bit sum cannot overflow.
    function automatic logic [11:0] add_lane(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= Q13) ? 12'(s - Q13) : s[11:0];
    endfunction

`ifdef POLY_WORD_SUB_EN
    // Borrow is folded back by adding Q before subtracting b.
    function automatic logic [11:0] sub_lane(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] d;
        d = (a < b) ? ({1'b0, a} + Q13 - {1'b0, b}) : ({1'b0, a} - {1'b0, b});
        return d[11:0];
    endfunction
`endif

    // Lane-wise combine of the two operand words currently on the read ports.
    always_comb begin
        dout_s = 96'd0;
        for (int j = 0; j < 8; j++) begin
`ifdef POLY_WORD_SUB_EN
            if (sub_r) begin
                dout_s[12*j +: 12] = sub_lane(rdata_a[12*j +: 12], rdata_b[12*j +: 12]);
            end else begin
                dout_s[12*j +: 12] = add_lane(rdata_a[12*j +: 12], rdata_b[12*j +: 12]);
            end
`else
            dout_s[12*j +: 12] = add_lane(rdata_a[12*j +: 12], rdata_b[12*j +: 12]);
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start) state_s = READ; else state_s = IDLE;
            READ:    if (rc_r == LAST) state_s = DRAIN; else state_s = READ;
            // Leave once this edge issues the final write.
            DRAIN:   if (vld_r && (wc_r == LAST)) state_s = DONE; else state_s = DRAIN;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered datapath: address generation, read-valid pipe and write side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_r      <= '0;
            wc_r      <= '0;
            a_off_r   <= '0;
            b_off_r   <= '0;
            dst_off_r <= '0;
            ren_r     <= 1'b0;
            vld_r     <= 1'b0;
            enw_r     <= 1'b0;
            raddr_a_r <= '0;
            raddr_b_r <= '0;
            waddr_r   <= '0;
            dout_r    <= 96'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef POLY_WORD_SUB_EN
            sub_r     <= 1'b0;
`endif
        end else begin
            // vld_r marks that rdata_* carries the word requested last cycle.
            vld_r <= ren_r;
            enw_r <= vld_r;
            if (vld_r) begin
                waddr_r <= dst_off_r + wc_r;
                dout_r  <= dout_s;
                wc_r    <= wc_r + 1'b1;
            end
            case (state_r)
                IDLE: begin
                    ren_r <= 1'b0;
                    if (start) begin
                        a_off_r   <= a_offset;
                        b_off_r   <= b_offset;
                        dst_off_r <= dst_offset;
                        rc_r      <= '0;
                        wc_r      <= '0;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
`ifdef POLY_WORD_SUB_EN
                        sub_r     <= sub;
`endif
                    end
                end
                READ: begin
                    ren_r     <= 1'b1;
                    raddr_a_r <= a_off_r + rc_r;
                    raddr_b_r <= b_off_r + rc_r;
                    rc_r      <= rc_r + 1'b1;
                end
                DRAIN: begin
                    ren_r <= 1'b0;
                end
                DONE: begin
                    ren_r  <= 1'b0;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    ren_r <= 1'b0;
                end
            endcase
        end
    end

    assign ren     = ren_r;
    assign raddr_a = raddr_a_r;
    assign raddr_b = raddr_b_r;
    assign enw     = enw_r;
    assign waddr   = waddr_r;
    assign dout    = dout_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_poly_word_adder.sv
// Directed testbench for poly_word_adder. A behavioural dual-read RAM with
// one-cycle read latency serves both operand ports and absorbs result writes.
module tb_poly_word_adder;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] a_offset = '0;
    logic [AW-1:0] b_offset = '0;
    logic [AW-1:0] dst_offset = '0;
`ifdef POLY_WORD_SUB_EN
    logic          sub = 1'b0;
`endif
    logic          ren;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [95:0]   rdata_a = 96'd0;
    logic [95:0]   rdata_b = 96'd0;
    logic          enw;
    logic [AW-1:0] waddr;
    logic [95:0]   dout;
    logic          busy;
    logic          done;

    logic [95:0]   mem [0:1023];
    logic [AW-1:0] wlog [$];
    int            checks = 0;
    int            errors = 0;

    poly_word_adder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_offset   (a_offset),
        .b_offset   (b_offset),
        .dst_offset (dst_offset),
`ifdef POLY_WORD_SUB_EN
        .sub        (sub),
`endif
        .ren        (ren),
        .raddr_a    (raddr_a),
        .raddr_b    (raddr_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .enw        (enw),
        .waddr      (waddr),
        .dout       (dout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // RAM model: registered reads, write log for address checks.
    always @(posedge clk) begin
        if (ren) begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
        if (enw) begin
            mem[waddr] <= dout;
            wlog.push_back(waddr);
        end
    end

    task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] log_at(input int i);
        if (i < wlog.size()) return 96'(wlog[i]);
        return {96{1'b1}};
    endfunction

    // Runs one pass; optionally re-pulses start (with junk offsets) after edge repulse.
    task automatic run_pass(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                            input int repulse, output int first_enw, output int done_at,
                            output int enw_cnt);
        wlog.delete();
        @(negedge clk);
        a_offset = a; b_offset = b; dst_offset = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", 96'(busy), 96'd1);
        check_val("done_cleared", 96'(done), 96'd0);
        first_enw = -1; done_at = -1; enw_cnt = 0;
        for (int n = 1; n <= 100 && done_at < 0; n++) begin
            if (n == repulse) begin
                start = 1'b1; a_offset = 10'd7; b_offset = 10'd9; dst_offset = 10'd11;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (enw) begin
                if (first_enw < 0) first_enw = n;
                enw_cnt++;
            end
            if (done) done_at = n;
        end
        start = 1'b0;
        if (done_at < 0) check_val("done_timeout", 96'd0, 96'd1);
        @(negedge clk);
    endtask

    initial begin
        int fe, da, ec;
        int cnt;
        logic [95:0] l0a, l0b, l0e;
        l0a = {12'd1664, 12'd2000, 12'd1, 12'd3328, 12'd1234, 12'd0, 12'd3000, 12'd3328};
        l0b = {12'd1665, 12'd1328, 12'd1, 12'd0,    12'd2000, 12'd0, 12'd3000, 12'd1};
        l0e = {12'd0,    12'd3328, 12'd2, 12'd3328, 12'd3234, 12'd0, 12'd2671, 12'd0};

        for (int i = 0; i < 1024; i++) mem[i] <= 96'd0;
        for (int i = 0; i < 32; i++) begin
            mem[i]       <= {8{12'd1000}};
            mem[32 + i]  <= {8{12'd2000}};
            mem[100 + i] <= {8{12'(100 * i)}};
            mem[200 + i] <= {8{12'(i)}};
            mem[400 + i] <= {8{12'd1000}};
            mem[500 + i] <= {8{12'd5}};
            mem[600 + i] <= {8{12'd10}};
        end
        mem[100] <= l0a;          mem[200] <= l0b;
        mem[101] <= {8{12'd3328}}; mem[201] <= {8{12'd1}};
        mem[102] <= {8{12'd3000}}; mem[202] <= {8{12'd3000}};
        mem[103] <= 96'd0;         mem[203] <= 96'd0;

        // Reset state and quiet idle.
        repeat (3) @(negedge clk);
        check_val("rst_ren", 96'(ren), 96'd0);
        check_val("rst_enw", 96'(enw), 96'd0);
        check_val("rst_busy", 96'(busy), 96'd0);
        check_val("rst_done", 96'(done), 96'd0);
        check_val("rst_raddr", 96'({raddr_a, raddr_b, waddr}), 96'd0);
        check_val("rst_dout", dout, 96'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ren || enw || busy) cnt++;
        end
        check_val("idle_quiet", 96'(cnt), 96'd0);

        // Basic pass 1000 + 2000.
        run_pass(10'd0, 10'd32, 10'd64, -1, fe, da, ec);
        check_val("first_enw_cycle", 96'(fe), 96'd3);
        check_val("done_cycle", 96'(da), 96'd35);
        check_val("enw_count", 96'(ec), 96'd32);
        check_val("log_size", 96'(wlog.size()), 96'd32);
        check_val("waddr_first", log_at(0), 96'd64);
        check_val("waddr_last", log_at(31), 96'd95);
        for (int k = 0; k < 32; k++) check_val($sformatf("sum3000_w%0d", k), mem[64 + k], {8{12'd3000}});
        check_val("busy_end", 96'(busy), 96'd0);
        check_val("done_sticky", 96'(done), 96'd1);

        // Lane boundaries, address wrap, ignored re-start with changed offsets.
        run_pass(10'd100, 10'd200, 10'd1020, 10, fe, da, ec);
        check_val("wrap_count", 96'(wlog.size()), 96'd32);
        check_val("wrap_w0", log_at(0), 96'd1020);
        check_val("wrap_w3", log_at(3), 96'd1023);
        check_val("wrap_w4", log_at(4), 96'd0);
        check_val("wrap_w31", log_at(31), 96'd27);
        check_val("lanes_distinct", mem[1020], l0e);
        check_val("lanes_3328p1", mem[1021], 96'd0);
        check_val("lanes_3000p3000", mem[1022], {8{12'd2671}});
        check_val("lanes_zero", mem[1023], 96'd0);
        for (int k = 4; k < 32; k++) check_val($sformatf("ramp_w%0d", k), mem[k - 4], {8{12'(101 * k)}});

        // Reset at write 12, then an in-place pass.
        wlog.delete();
        @(negedge clk);
        a_offset = 10'd400; b_offset = 10'd32; dst_offset = 10'd300; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 12; n++) begin
            @(negedge clk);
            if (enw) cnt++;
        end
        check_val("reach_write12", 96'(cnt), 96'd12);
        rst = 1'b1;
        #1;
        check_val("midrst_enw", 96'(enw), 96'd0);
        check_val("midrst_busy", 96'(busy), 96'd0);
        check_val("midrst_done", 96'(done), 96'd0);
        @(negedge clk);
        rst = 1'b0;
        wlog.delete();
        repeat (40) @(negedge clk);
        check_val("no_writes_after_rst", 96'(wlog.size()), 96'd0);
        run_pass(10'd400, 10'd32, 10'd400, -1, fe, da, ec);
        check_val("inplace_count", 96'(ec), 96'd32);
        check_val("inplace_w0", mem[400], {8{12'd3000}});
        check_val("inplace_w31", mem[431], {8{12'd3000}});

`ifdef POLY_WORD_SUB_EN
        sub = 1'b1;
        run_pass(10'd500, 10'd600, 10'd700, -1, fe, da, ec);
        check_val("sub_5m10", mem[700], {8{12'd3324}});
        run_pass(10'd600, 10'd500, 10'd700, -1, fe, da, ec);
        check_val("sub_10m5", mem[700], {8{12'd5}});
        sub = 1'b0;
        run_pass(10'd500, 10'd600, 10'd700, -1, fe, da, ec);
        check_val("add_5p10", mem[700], {8{12'd15}});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
